pwd_serializer: RTL and testbench
=================================

Name: pwd_serializer

Overview:
- Upstream feeder for the serial unlock FSM.
- Accepts a parallel password code word over a valid/ready handshake and shifts it out MSB first, one bit per serial handshake.
- Drives the FSM's serial_data/serial_valid pair and honours its serial_ready back-pressure.
- Reports frame completion, and aborts the frame if the downstream stalls too long.

Parameters:
- WIDTH, 4, code word width in bits; legal range 1..16.
- GAP_CYCLES, 1, idle cycles with serial_valid=0 inserted between accepted bits; 0 = back-to-back.
- TIMEOUT_CYCLES, 16, consecutive cycles of serial_valid=1 with serial_ready=0 before the frame is aborted; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- code_data  input  WIDTH  parallel code word; sampled on code handshake.
- code_valid  input  1  code_data is valid.
- code_ready  output  1  block is idle and can accept a code word.
- serial_data  output  1  current bit to downstream; MSB first.
- serial_valid  output  1  serial_data is valid.
- serial_ready  input  1  downstream accepts a bit this cycle.
- busy  output  1  a frame is in progress (SEND or GAP).
- done  output  1  one-cycle pulse after the last bit is accepted.
- timeout_err  output  1  one-cycle pulse when a frame is aborted on timeout.

Behaviour:
- All outputs are registered.
- Reset values: code_ready=0, serial_valid=0, serial_data=0, busy=0, done=0, timeout_err=0. The shift register and counters are cleared. State is IDLE.
- code_ready rises on the first edge after reset deasserts.
- Reset mid-frame: the frame is discarded silently. No done pulse, no timeout_err pulse.

States:
- IDLE
  - code_ready=1.
  - On code_valid && code_ready at edge N: latch code_data, bit index = WIDTH-1, go to SEND.
  - After edge N: serial_valid=1, serial_data=code_data[WIDTH-1], code_ready=0, busy=1.
- SEND
  - serial_valid=1; serial_data holds stable until accepted.
  - Acceptance = serial_valid && serial_ready at an edge.
  - On acceptance with bits remaining:
    - index is decremented;
    - if GAP_CYCLES>0, go to GAP (serial_valid=0);
    - else stay in SEND and present the next bit on the following cycle.
  - On acceptance of bit 0: go to DONE.
  - Stall counter: increments each cycle in SEND without acceptance, clears on acceptance.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES: go to IDLE with timeout_err pulsed for one cycle, serial_valid=0, busy=0, frame dropped.
- GAP
  - serial_valid=0 for exactly GAP_CYCLES cycles, then return to SEND with the next bit.
  - serial_ready is ignored in GAP.
- DONE
  - One cycle: done=1, busy=0, serial_valid=0, code_ready=0.
  - Then IDLE; code_ready=1 on the next cycle.

Handshake and boundary rules:
- A code word that arrives while not in IDLE is not accepted; the upstream must hold code_valid.
- serial_valid is never deasserted before acceptance except on timeout or reset.
- Frame latency with serial_ready tied high: WIDTH + (WIDTH-1)*GAP_CYCLES cycles of SEND/GAP, plus 1 cycle of DONE.
- WIDTH=1: SEND goes straight to DONE after one acceptance.
- done and timeout_err are never asserted in the same cycle.
- The counter width is derived from the larger of GAP_CYCLES and TIMEOUT_CYCLES, with no wrap-around: the stall counter saturates at TIMEOUT_CYCLES.

Decomposition:
- Shared package pwd_pkg:
  - PWD_WIDTH constant (4), shared with the unlock FSM;
  - state enum ser_state_t {IDLE, SEND, GAP, DONE};
  - a function returning the counter width.
- One sub-module, cycle_counter: loadable down-counter with a zero flag. It is instantiated twice, once for the gap count and once for the stall/timeout count.

Test Plan:
- Reset, then code 4'b1011, serial_ready=1, GAP=1 -> accepted bits 1,0,1,1 in order; serial_valid low for exactly 1 cycle between bits; done pulses once 8 cycles after the code handshake; code_ready=1 the next cycle.
- Code 4'b1001 with serial_ready toggling 0/1 every cycle -> each bit held stable until accepted; sequence 1,0,0,1; no timeout_err.
- Code 4'b0011, serial_ready held 0 after the first bit is accepted, TIMEOUT=16 -> timeout_err pulses exactly 16 cycles into the stall; no done; IDLE with code_ready=1.
- Reset asserted two cycles after accepting 4'b1111 -> all outputs 0 during reset; no done or timeout_err; next code 4'b1011 serializes correctly.
- code_valid held high with a new word (4'b0101) during a frame -> not accepted until after done; then serialized 0,1,0,1.
- GAP_CYCLES=0, WIDTH=4, serial_ready=1 -> four consecutive accepted cycles, then done on the 5th.

Source files
------------

// File: rtl/pwd_pkg.sv
// Shared types and constants for the password serializer and unlock FSM.
// Holds the code width, the serializer state encoding and counter sizing.
package pwd_pkg;

    localparam int PWD_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } ser_state_t;

    // Counters are loaded with (cycles - 1), so the widest load value
    // is max(gap, timeout) - 1.
    function automatic int ser_cnt_width(input int gap, input int tmo);
        int m;
        m = (gap > tmo) ? gap : tmo;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pwd_serializer_cycle_counter.sv
// Loadable down-counter with a zero flag.
// Decrement saturates at zero so the count never wraps.
module cycle_counter
    import pwd_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    // Load has priority over decrement; hold at zero once reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pwd_serializer.sv
// Parallel-to-serial feeder for the unlock FSM, MSB first.
// Optional idle gap between bits and a stall timeout that drops the frame.
module pwd_serializer
    import pwd_pkg::*;
#(
    parameter int WIDTH          = PWD_WIDTH,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] code_data,
    input  logic             code_valid,
    output logic             code_ready,
    output logic             serial_data,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int CW = ser_cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [CW-1:0] TO_LOAD =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bits_left;
    logic             r_code_ready;
    logic             r_serial_data;
    logic             r_serial_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout_err;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_accept;
    logic             w_stall;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_gap_zero;
    logic             w_stall_load;
    logic             w_stall_zero;
    logic             w_timeout;

    assign w_shift_next = r_shift << 1;
    assign w_accept     = (r_state == SEND) && r_serial_valid && serial_ready;
    assign w_stall      = (r_state == SEND) && !serial_ready;

    // Gap counter is armed on every non-final acceptance.
    assign w_gap_load = w_accept && (r_bits_left != '0);
    assign w_gap_dec  = (r_state == GAP);

    // Stall counter rearms outside SEND and on every acceptance.
    assign w_stall_load = (r_state != SEND) || w_accept;
    assign w_timeout    = (TIMEOUT_CYCLES > 0) && w_stall && w_stall_zero;

    cycle_counter #(
        .CW (CW)
    ) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero)
    );

    cycle_counter #(
        .CW (CW)
    ) u_stall_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_stall_load),
        .i_load_val (TO_LOAD),
        .i_dec      (w_stall),
        .o_zero     (w_stall_zero)
    );

    // Frame FSM with all handshake and status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_bits_left    <= '0;
            r_code_ready   <= 1'b0;
            r_serial_data  <= 1'b0;
            r_serial_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (code_valid && r_code_ready) begin
                        r_shift        <= code_data;
                        r_bits_left    <= BIT_LOAD;
                        r_serial_data  <= code_data[WIDTH-1];
                        r_serial_valid <= 1'b1;
                        r_code_ready   <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= SEND;
                    end else begin
                        r_code_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (r_bits_left == '0) begin
                            r_serial_valid <= 1'b0;
                            r_busy         <= 1'b0;
                            r_done         <= 1'b1;
                            r_state        <= DONE;
                        end else begin
                            r_shift     <= w_shift_next;
                            r_bits_left <= r_bits_left - BW'(1);
                            if (GAP_CYCLES > 0) begin
                                r_serial_valid <= 1'b0;
                                r_state        <= GAP;
                            end else begin
                                r_serial_data <= w_shift_next[WIDTH-1];
                            end
                        end
                    end else if (w_timeout) begin
                        r_serial_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_timeout_err  <= 1'b1;
                        r_code_ready   <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                GAP: begin
                    if (w_gap_zero) begin
                        r_serial_data  <= r_shift[WIDTH-1];
                        r_serial_valid <= 1'b1;
                        r_state        <= SEND;
                    end
                end
                DONE: begin
                    r_code_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign code_ready   = r_code_ready;
    assign serial_data  = r_serial_data;
    assign serial_valid = r_serial_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_pwd_serializer.sv
// Bench for pwd_serializer: two instances (gap 1 and gap 0) driven from
// one sequence, checked against a bit-queue model of each frame.
module tb_pwd_serializer;

    localparam int W  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cv  = 1'b0;
    logic [W-1:0] cd  = '0;
    logic         sr  = 1'b0;
    bit           sel = 1'b0;

    logic a_cr, a_sd, a_sv, a_busy, a_done, a_to;
    logic b_cr, b_sd, b_sv, b_busy, b_done, b_to;
    logic o_cr, o_sd, o_sv, o_busy, o_done, o_to;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwd_serializer #(
        .WIDTH          (W),
        .GAP_CYCLES     (1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .code_data    (cd),
        .code_valid   (cv & ~sel),
        .code_ready   (a_cr),
        .serial_data  (a_sd),
        .serial_valid (a_sv),
        .serial_ready (sr),
        .busy         (a_busy),
        .done         (a_done),
        .timeout_err  (a_to)
    );

    pwd_serializer #(
        .WIDTH          (W),
        .GAP_CYCLES     (0),
        .TIMEOUT_CYCLES (TO)
    ) dut0 (
        .clk          (clk),
        .reset        (rst),
        .code_data    (cd),
        .code_valid   (cv & sel),
        .code_ready   (b_cr),
        .serial_data  (b_sd),
        .serial_valid (b_sv),
        .serial_ready (sr),
        .busy         (b_busy),
        .done         (b_done),
        .timeout_err  (b_to)
    );

    assign o_cr   = sel ? b_cr   : a_cr;
    assign o_sd   = sel ? b_sd   : a_sd;
    assign o_sv   = sel ? b_sv   : a_sv;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_to   = sel ? b_to   : a_to;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ready high, 1 toggling, 2 random, 3 stall after first bit
    task automatic run_frame(input logic [W-1:0] code, input int mode,
                             input bit expect_to, input bit hold_next,
                             input logic [W-1:0] next);
        bit   q[$];
        int   k;
        int   g;
        int   gap_run;
        int   stall_run;
        int   accepted;
        bit   in_gap;
        bit   prev_hold;
        logic prev_data;
        bit   got_done;
        bit   got_to;
        g = sel ? 0 : 1;
        for (int i = W - 1; i >= 0; i--) q.push_back(code[i]);
        k = 0;
        while (!o_cr && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("cr_wait", o_cr, 1);
        cv = 1'b1;
        cd = code;
        sr = 1'b0;
        @(negedge clk);
        cv = hold_next;
        if (hold_next) cd = next;
        chk("hs_valid", o_sv, 1);
        chk("hs_data", o_sd, code[W-1]);
        chk("hs_busy", o_busy, 1);
        chk("hs_cr", o_cr, 0);
        k = 1;
        gap_run = 0;
        stall_run = 0;
        accepted = 0;
        in_gap = 0;
        prev_hold = 0;
        prev_data = 1'b0;
        got_done = 0;
        got_to = 0;
        while (k < 200 && !got_done && !got_to) begin
            if (o_done) begin
                got_done = 1;
                chk("done_left", q.size(), 0);
                chk("done_busy", o_busy, 0);
                chk("done_sv", o_sv, 0);
                chk("done_not_to", o_to, 0);
                if (mode == 0) chk("done_lat", k, W + (W - 1) * g + 1);
            end else if (o_to) begin
                got_to = 1;
                chk("to_expected", expect_to, 1);
                chk("to_stall", stall_run, TO);
                chk("to_busy", o_busy, 0);
                chk("to_sv", o_sv, 0);
            end else if (o_sv) begin
                chk("sv_busy", o_busy, 1);
                if (hold_next) chk("no_early_cr", o_cr, 0);
                if (prev_hold) chk("hold", o_sd, prev_data);
                if (in_gap) begin
                    chk("gap_len", gap_run, g);
                    in_gap = 0;
                end
                chk("bit_avail", q.size() > 0, 1);
                if (q.size() > 0) chk("bit", o_sd, q[0]);
                case (mode)
                    0: sr = 1'b1;
                    1: sr = k[0];
                    2: sr = (stall_run >= 10) ? 1'b1 : 1'($urandom % 2);
                    default: sr = (accepted == 0);
                endcase
                if (sr) begin
                    if (q.size() > 0) void'(q.pop_front());
                    accepted++;
                    stall_run = 0;
                    prev_hold = 0;
                    in_gap = 1;
                    gap_run = 0;
                end else begin
                    stall_run++;
                    prev_hold = 1;
                    prev_data = o_sd;
                end
            end else begin
                chk("gap_busy", o_busy, 1);
                gap_run++;
                prev_hold = 0;
                sr = 1'($urandom % 2);
            end
            @(negedge clk);
            k++;
        end
        sr = 1'b0;
        chk("frame_ended", got_done | got_to, 1);
        chk("end_kind", got_to, expect_to);
        chk("cr_after", o_cr, 1);
        chk("pulse_once", o_done | o_to, 0);
    endtask

    initial begin
        logic [W-1:0] rc;
        repeat (3) @(negedge clk);
        chk("rst_cr", o_cr, 0);
        chk("rst_sv", o_sv, 0);
        chk("rst_sd", o_sd, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_to", o_to, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("cr_rise", o_cr, 1);

        run_frame(4'b1011, 0, 0, 0, '0);
        run_frame(4'b1001, 1, 0, 0, '0);
        run_frame(4'b0011, 3, 1, 0, '0);

        cv = 1'b1;
        cd = 4'b1111;
        sr = 1'b1;
        @(negedge clk);
        cv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_out",
                {28'd0, o_cr, o_sv, o_sd, o_busy}, 0);
            chk("mid_rst_pulse", o_done | o_to, 0);
        end
        rst = 1'b0;
        sr = 1'b0;
        @(negedge clk);
        chk("post_rst_cr", o_cr, 1);
        run_frame(4'b1011, 0, 0, 0, '0);

        run_frame(4'b1011, 0, 0, 1, 4'b0101);
        run_frame(4'b0101, 0, 0, 0, '0);

        sel = 1'b1;
        @(negedge clk);
        run_frame(4'b1011, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            rc = W'($urandom_range(0, 15));
            run_frame(rc, 2, 0, 0, '0);
        end
        sel = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rc = W'($urandom_range(0, 15));
            run_frame(rc, 2, 0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
